// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared constants and helpers for the seven-segment scan driver
// Purpose: hex-to-segment table (active-high, bit order {g,f,e,d,c,b,a}),
//          pin polarity helper and a counter width helper that never returns 0.
// Ports:   none (package).
package seg7_pkg;

  // Index = nibble value, first entry listed is nibble F.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  // Width needed to count 0..n-1; a 1-state counter still gets one bit.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Converts a logical "on" bit into the level driven on the board pin.
  function automatic logic to_pin(input logic active, input logic active_low);
    return active ^ active_low;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - combinational hex nibble to seven-segment pattern
// Purpose: looks up the active-high {g,f,e,d,c,b,a} pattern for one nibble.
// Ports:   nib_i - hex nibble in
//          seg_o - active-high segment pattern out
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG_TABLE[nib_i];

endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - multiplexed seven-segment display scanner
// Purpose: time-multiplexes DIGITS hex nibbles onto shared segment lines with
//          frame-synchronous loading, leading-zero suppression, blink, decimal
//          points, global blank and selectable pin polarity.
// Ports:   clk_in      - system clock
//          rst         - synchronous active-high reset
//          data        - DIGITS hex nibbles, nibble i drives digit i (0 = rightmost)
//          load        - strobe capturing data for display at the next frame
//          dp_en       - decimal point enable per digit
//          blink_en    - blink enable per digit
//          lz_suppress - blank leading zero digits
//          blank       - force whole display off
//          seg         - segment pins {g,f,e,d,c,b,a}
//          dp          - decimal point pin
//          an          - digit anode pins, one-hot active
//          frame_tick  - one-cycle pulse after the last digit completes
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIGITS       = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLINK_FRAMES = 64,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic                  clk_in,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   data,
  input  logic                  load,
  input  logic [DIGITS-1:0]     dp_en,
  input  logic [DIGITS-1:0]     blink_en,
  input  logic                  lz_suppress,
  input  logic                  blank,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_tick
);

  localparam int IW = cnt_width(DIGITS);
  localparam int PW = cnt_width(REFRESH_DIV);
  localparam int BW = cnt_width(BLINK_FRAMES);

  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);
  localparam logic [PW-1:0] PRE_LAST   = PW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);
  localparam logic          AL         = (ACTIVE_LOW != 0);

  logic [PW-1:0]         pre_q, pre_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [4*DIGITS-1:0]   staging_q, staging_d;
  logic [4*DIGITS-1:0]   shadow_q, shadow_d;
  logic                  pending_q, pending_d;
  logic [BW-1:0]         bcnt_q, bcnt_d;
  logic                  phase_q, phase_d;
  logic                  tick_q, tick_d;
  logic [DIGITS-1:0]     an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;

  logic                  tc;
  logic                  frame_end;
  logic [3:0]            cur_nib;
  logic [6:0]            cur_pat;
  logic [DIGITS-1:0]     upper_zero;
  logic                  visible;

  seg7_decode u_decode (
    .nib_i (cur_nib),
    .seg_o (cur_pat)
  );

  // Scan timing, frame-synchronous shadow update and blink phase.
  always_comb begin
    tc        = (pre_q == PRE_LAST);
    frame_end = tc && (idx_q == IDX_LAST);

    pre_d = tc ? '0 : pre_q + PW'(1);

    idx_d = idx_q;
    if (tc) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
    end

    staging_d = staging_q;
    pending_d = pending_q;
    shadow_d  = shadow_q;
    if (load) begin
      staging_d = data;
      pending_d = 1'b1;
    end
    // A load on the frame-end cycle itself bypasses staging so it is not lost
    // for a whole frame.
    if (frame_end) begin
      if (load) begin
        shadow_d = data;
      end else if (pending_q) begin
        shadow_d = staging_q;
      end
      pending_d = 1'b0;
    end

    bcnt_d  = bcnt_q;
    phase_d = phase_q;
    if (frame_end) begin
      if (bcnt_q == BLINK_LAST) begin
        bcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        bcnt_d = bcnt_q + BW'(1);
      end
    end

    tick_d = frame_end;
  end

  // upper_zero[i]: nibbles i..DIGITS-1 of the shadow are all zero.
  always_comb begin
    upper_zero = '0;
    upper_zero[DIGITS-1] = (shadow_q[4*DIGITS-1 -: 4] == 4'h0);
    for (int k = DIGITS - 2; k >= 0; k--) begin
      upper_zero[k] = upper_zero[k+1] && (shadow_q[4*k +: 4] == 4'h0);
    end
  end

  // Visibility and pin levels for the digit currently being scanned.
  always_comb begin
    cur_nib = shadow_q[4*int'(idx_q) +: 4];

    visible = 1'b1;
    if (blank) begin
      visible = 1'b0;
    end
    if (blink_en[idx_q] && phase_q) begin
      visible = 1'b0;
    end
    if (lz_suppress && (idx_q != '0) && upper_zero[idx_q]) begin
      visible = 1'b0;
    end

    an_d = '0;
    for (int k = 0; k < DIGITS; k++) begin
      an_d[k] = to_pin(visible && (int'(idx_q) == k), AL);
    end

    seg_d = '0;
    for (int k = 0; k < 7; k++) begin
      seg_d[k] = to_pin(visible && cur_pat[k], AL);
    end

    dp_d = to_pin(visible && dp_en[idx_q], AL);
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      pre_q     <= '0;
      idx_q     <= '0;
      staging_q <= '0;
      shadow_q  <= '0;
      pending_q <= 1'b0;
      bcnt_q    <= '0;
      phase_q   <= 1'b0;
      tick_q    <= 1'b0;
      an_q      <= {DIGITS{AL}};
      seg_q     <= {7{AL}};
      dp_q      <= AL;
    end else begin
      pre_q     <= pre_d;
      idx_q     <= idx_d;
      staging_q <= staging_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      bcnt_q    <= bcnt_d;
      phase_q   <= phase_d;
      tick_q    <= tick_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - self-checking bench for seg7_scan_driver
module tb_seg7_scan_driver;

  localparam int DIGITS       = 4;
  localparam int REFRESH_DIV  = 4;
  localparam int BLINK_FRAMES = 2;
  localparam int FRAME        = DIGITS * REFRESH_DIV;

  logic        clk_in      = 1'b0;
  logic        rst         = 1'b1;
  logic [15:0] data        = '0;
  logic        load        = 1'b0;
  logic [3:0]  dp_en       = '0;
  logic [3:0]  blink_en    = '0;
  logic        lz_suppress = 1'b0;
  logic        blank       = 1'b0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_tick;

  seg7_scan_driver #(
    .DIGITS       (DIGITS),
    .REFRESH_DIV  (REFRESH_DIV),
    .BLINK_FRAMES (BLINK_FRAMES),
    .ACTIVE_LOW   (1)
  ) dut (
    .clk_in      (clk_in),
    .rst         (rst),
    .data        (data),
    .load        (load),
    .dp_en       (dp_en),
    .blink_en    (blink_en),
    .lz_suppress (lz_suppress),
    .blank       (blank),
    .seg         (seg),
    .dp          (dp),
    .an          (an),
    .frame_tick  (frame_tick)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int         at;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    string      tag;
  } exp_t;

  typedef struct {
    logic [15:0] data;
    logic [3:0]  dpen;
    logic        lz;
    logic [3:0]  vis;
    logic [6:0]  s0, s1, s2, s3;
  } vec_t;

  exp_t sb[$];
  vec_t vt[10];
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act === want) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0h, want %0h", name, cyc, act, want);
  endfunction

  function automatic void push_digit(input int at, input int d, input logic vis,
                                     input logic [6:0] segv, input logic dpv, input string tag);
    exp_t e;
    logic [3:0] one_hot;
    one_hot = 4'b0001 << d;
    e.at  = at;
    e.an  = vis ? ~one_hot : 4'hF;
    e.seg = vis ? segv : 7'h7F;
    e.dp  = ~(vis & dpv);
    e.tag = tag;
    sb.push_back(e);
  endfunction

  function automatic void push_frame(input int fs, input logic [6:0] s0, input logic [6:0] s1,
                                     input logic [6:0] s2, input logic [6:0] s3,
                                     input logic [3:0] vis, input logic [3:0] dpen, input string tag);
    logic [6:0] s [4];
    s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
    for (int d = 0; d < DIGITS; d++)
      for (int c = 0; c < REFRESH_DIV; c++)
        push_digit(fs + REFRESH_DIV * d + c, d, vis[d], s[d], dpen[d], $sformatf("%s.d%0d", tag, d));
  endfunction

  // First sample index of the frame after the one holding the current state.
  function automatic int next_fs();
    return FRAME * (cyc / FRAME + 1) + 1;
  endfunction

  task automatic step();
    @(posedge clk_in);
    #1;
    cyc++;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].at == cyc) begin
        check({sb[i].tag, ".an"},  32'(an),  32'(sb[i].an));
        check({sb[i].tag, ".seg"}, 32'(seg), 32'(sb[i].seg));
        check({sb[i].tag, ".dp"},  32'(dp),  32'(sb[i].dp));
        sb.delete(i);
      end
    end
  endtask

  task automatic run_to(input int k);
    while (cyc < k) step();
  endtask

  task automatic do_load(input logic [15:0] d);
    data = d;
    load = 1'b1;
    step();
    load = 1'b0;
    data = 16'($urandom);
  endtask

  task automatic check_off(input string name);
    check({name, ".an"},   32'(an),         32'h0F);
    check({name, ".seg"},  32'(seg),        32'h7F);
    check({name, ".dp"},   32'(dp),         32'h1);
    check({name, ".tick"}, 32'(frame_tick), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int fs;
    int f0;
    int t;
    logic vis0;

    vt[0] = '{16'h12AF, 4'b0010, 1'b0, 4'b1111, 7'h0E, 7'h08, 7'h24, 7'h79};
    vt[1] = '{16'h3456, 4'b0000, 1'b0, 4'b1111, 7'h02, 7'h12, 7'h19, 7'h30};
    vt[2] = '{16'h789B, 4'b1001, 1'b0, 4'b1111, 7'h03, 7'h10, 7'h00, 7'h78};
    vt[3] = '{16'hCDEF, 4'b1111, 1'b0, 4'b1111, 7'h0E, 7'h06, 7'h21, 7'h46};
    vt[4] = '{16'h0030, 4'b0000, 1'b1, 4'b0011, 7'h40, 7'h30, 7'h7F, 7'h7F};
    vt[5] = '{16'h0000, 4'b0000, 1'b1, 4'b0001, 7'h40, 7'h7F, 7'h7F, 7'h7F};
    vt[6] = '{16'h0105, 4'b0000, 1'b1, 4'b0111, 7'h12, 7'h40, 7'h79, 7'h7F};
    vt[7] = '{16'h8000, 4'b0000, 1'b1, 4'b1111, 7'h40, 7'h40, 7'h40, 7'h00};
    vt[8] = '{16'h0000, 4'b0100, 1'b0, 4'b1111, 7'h40, 7'h40, 7'h40, 7'h40};
    vt[9] = '{16'h0000, 4'b1000, 1'b1, 4'b0001, 7'h40, 7'h7F, 7'h7F, 7'h7F};

    // Reset state, first digit after release, first frame_tick.
    rst = 1'b1;
    repeat (3) step();
    check_off("reset");
    rst = 1'b0;
    cyc = 0;
    push_digit(1, 0, 1'b1, 7'h40, 1'b0, "release");
    for (int k = 1; k <= FRAME + 1; k++) begin
      step();
      check("frame_tick", 32'(frame_tick), 32'(cyc == FRAME));
    end

    // Table: each vector is loaded and checked over the whole next frame.
    for (int v = 0; v < 10; v++) begin
      dp_en       = vt[v].dpen;
      lz_suppress = vt[v].lz;
      fs = next_fs();
      push_frame(fs, vt[v].s0, vt[v].s1, vt[v].s2, vt[v].s3, vt[v].vis, vt[v].dpen,
                 $sformatf("vec%0d", v));
      do_load(vt[v].data);
      run_to(fs + FRAME - 1);
    end

    // Tear-free update: a load mid-frame leaves the rest of that frame alone.
    lz_suppress = 1'b0;
    dp_en = 4'b0000;
    fs = next_fs();
    push_frame(fs, 7'h79, 7'h79, 7'h79, 7'h79, 4'hF, 4'h0, "tear_old");
    do_load(16'h1111);
    run_to(fs + REFRESH_DIV - 1);
    push_frame(fs + FRAME, 7'h24, 7'h24, 7'h24, 7'h24, 4'hF, 4'h0, "tear_new");
    do_load(16'h2222);

    // Several loads in one frame: the last one wins.
    run_to(fs + FRAME + 1);
    do_load(16'h3333);
    step();
    do_load(16'h4444);
    push_frame(fs + 2 * FRAME, 7'h19, 7'h19, 7'h19, 7'h19, 4'hF, 4'h0, "last_wins");

    // Load on the frame-end cycle shows from the very next frame, then holds.
    run_to(fs + 3 * FRAME - 2);
    push_frame(fs + 3 * FRAME, 7'h12, 7'h12, 7'h12, 7'h12, 4'hF, 4'h0, "fe_load");
    do_load(16'h5555);
    push_frame(fs + 4 * FRAME, 7'h12, 7'h12, 7'h12, 7'h12, 4'hF, 4'h0, "hold");
    run_to(fs + 5 * FRAME - 1);

    // Blink on digit 0: hidden in frames whose blink phase is odd.
    blink_en = 4'b0001;
    f0 = cyc / FRAME + 1;
    for (int f = f0; f < f0 + 4; f++) begin
      vis0 = (((f / BLINK_FRAMES) % 2) == 0);
      push_frame(FRAME * f + 1, 7'h12, 7'h12, 7'h12, 7'h12, {3'b111, vis0}, 4'h0,
                 $sformatf("blink_f%0d", f));
    end
    run_to(FRAME * (f0 + 4));
    blink_en = 4'b0000;

    // Global blank takes effect one cycle later and releases the same way.
    blank = 1'b1;
    t = cyc;
    for (int j = 1; j <= 6; j++) push_digit(t + j, 0, 1'b0, 7'h7F, 1'b0, "blank");
    run_to(t + 6);
    blank = 1'b0;
    push_digit(cyc + 1, (cyc / REFRESH_DIV) % DIGITS, 1'b1, 7'h12, 1'b0, "unblank");
    step();

    // Reset in the middle of digit 2 of a frame showing 12AF.
    dp_en = 4'b0010;
    fs = next_fs();
    push_frame(fs, 7'h0E, 7'h08, 7'h24, 7'h79, 4'hF, 4'b0010, "pre_rst");
    do_load(16'h12AF);
    run_to(fs + 2 * REFRESH_DIV - 1);
    sb.delete();
    rst = 1'b1;
    step();
    check_off("mid_reset");
    rst = 1'b0;
    cyc = 0;
    push_digit(1, 0, 1'b1, 7'h40, 1'b0, "post_rst.d0");
    push_digit(REFRESH_DIV + 1, 1, 1'b1, 7'h40, 1'b1, "post_rst.d1");
    run_to(FRAME - 1);
    check("post_rst.tick_lo", 32'(frame_tick), 32'h0);
    step();
    check("post_rst.tick_hi", 32'(frame_tick), 32'h1);

    if (sb.size() != 0) begin
      n_checks++;
      $display("FAIL scoreboard: %0d expectations never reached", sb.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
